// File: rtl/dla_rand_arbiter.sv
// dla_rand_arbiter: round-robin front end for a single shared LFSR.
// Serves bounded random numbers by rejection sampling the LFSR low bits.
// Falls back to 0 after MAX_TRIES rejected attempts.
module dla_rand_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 16,
   parameter int OUT_W     = 10,
   parameter int SHIFTS    = 4,
   parameter int MAX_TRIES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*OUT_W-1:0] req_limit,
   output logic                  lfsr_shift,
   input  logic [WIDTH-1:0]      lfsr_value,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       rvalid,
   output logic [OUT_W-1:0]      rdata,
   output logic                  fallback
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(SHIFTS + 1);
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   typedef enum logic [1:0] {IDLE, MIX, CHECK, RESP} state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   win;
   logic [OUT_W-1:0]   lim_q;
   logic [CNT_W-1:0]   mix_cnt;
   logic [TRY_W-1:0]   tries;

   logic [OUT_W-1:0]   lim_arr [NREQ];
   logic [OUT_W-1:0]   sample;
   logic               accept;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   cand;

   // Split the flat limit bus into one entry per requester.
   for (genvar i = 0; i < NREQ; i++) begin : g_lim
      assign lim_arr[i] = req_limit[i*OUT_W +: OUT_W];
   end

   // Only the low OUT_W bits of the LFSR state feed the sampler.
   if (WIDTH > OUT_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^lfsr_value[WIDTH-1:OUT_W];
   end

   assign sample = lfsr_value[OUT_W-1:0];
   // A zero limit stands for the full 2^OUT_W range, so it never rejects.
   assign accept = (lim_q == '0) || (sample < lim_q);

   // Round-robin pick: first set request at or after rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Transaction FSM; all outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         win        <= '0;
         lim_q      <= '0;
         mix_cnt    <= '0;
         tries      <= '0;
         gnt        <= '0;
         rvalid     <= '0;
         rdata      <= '0;
         fallback   <= 1'b0;
         lfsr_shift <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt        <= NREQ'(1) << pick_idx;
                  win        <= pick_idx;
                  lim_q      <= lim_arr[pick_idx];
                  mix_cnt    <= '0;
                  lfsr_shift <= 1'b1;
                  state      <= MIX;
               end
            end
            MIX: begin
               if (mix_cnt == CNT_W'(SHIFTS - 1)) begin
                  mix_cnt    <= '0;
                  lfsr_shift <= 1'b0;
                  state      <= CHECK;
               end else begin
                  mix_cnt <= mix_cnt + CNT_W'(1);
               end
            end
            CHECK: begin
               if (accept) begin
                  rdata  <= sample;
                  rvalid <= gnt;
                  state  <= RESP;
               end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
                  rdata    <= '0;
                  fallback <= 1'b1;
                  rvalid   <= gnt;
                  state    <= RESP;
               end else begin
                  tries      <= tries + TRY_W'(1);
                  mix_cnt    <= '0;
                  lfsr_shift <= 1'b1;
                  state      <= MIX;
               end
            end
            RESP: begin
               rvalid   <= '0;
               fallback <= 1'b0;
               gnt      <= '0;
               tries    <= '0;
               rr_ptr   <= (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
